mem_access: RTL and testbench

Memory-access pipeline stage that sits between execute and wback. It accepts one instruction at a time from execute over a valid/ready handshake. Loads and stores go out on a single-outstanding request/response data-memory port; loads are aligned and extended before being passed on. The write-back and CSR fields then go to wback over a valid/ready handshake, and non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_if.sv | 53 +++++
 rtl/mem_access.sv | 166 ++++++++++++++++
 tb/tb_mem_access.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Signal bundle for the mem_access stage: execute-side input, wback-side
// output and the single-outstanding data-memory request/response port.
interface mem_access_if;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic        valid_post_o;
  logic        ready_post_i;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [2:0]  func3_i;
  logic [31:0] rs2_data_i;
  logic        wsel_i;
  logic        wena_i;
  logic [4:0]  waddr_i;
  logic [31:0] alu_result_i;
  logic        csr_wena_i;
  logic [31:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_wen_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_rdata_i;
  logic        wsel_o;
  logic        wena_o;
  logic [4:0]  waddr_o;
  logic [31:0] alu_result_o;
  logic [31:0] mem_result_o;
  logic        csr_wena_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  modport slave (
    input  valid_pre_i, ready_post_i, mem_ren_i, mem_wen_i, func3_i, rs2_data_i,
           wsel_i, wena_i, waddr_i, alu_result_i, csr_wena_i, csr_waddr_i, csr_wdata_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_rdata_i,
    output ready_pre_o, valid_post_o, mem_req_valid_o, mem_req_wen_o, mem_req_addr_o,
           mem_req_wdata_o, mem_req_wstrb_o, wsel_o, wena_o, waddr_o, alu_result_o,
           mem_result_o, csr_wena_o, csr_waddr_o, csr_wdata_o
  );

  modport master (
    output valid_pre_i, ready_post_i, mem_ren_i, mem_wen_i, func3_i, rs2_data_i,
           wsel_i, wena_i, waddr_i, alu_result_i, csr_wena_i, csr_waddr_i, csr_wdata_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_rdata_i,
    input  ready_pre_o, valid_post_o, mem_req_valid_o, mem_req_wen_o, mem_req_addr_o,
           mem_req_wdata_o, mem_req_wstrb_o, wsel_o, wena_o, waddr_o, alu_result_o,
           mem_result_o, csr_wena_o, csr_waddr_o, csr_wdata_o
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one instruction in flight, single outstanding
// data-memory request, load alignment/extension and store lane formatting.
module mem_access (
  input  logic        clock,
  input  logic        reset,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RESP = 2'b10, OUT = 2'b11} state_t;

  function automatic logic [31:0] load_extend(input logic [2:0] func3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    byte_s = rdata[{off, 3'b000} +: 8];
    half_s = off[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  res_s = {{16{half_s[15]}}, half_s};
      3'b100:  res_s = {24'h000000, byte_s};
      3'b101:  res_s = {16'h0000, half_s};
      default: res_s = rdata;
    endcase
    return res_s;
  endfunction

  // Returns {wdata, wstrb}; codes other than byte/half store a full word.
  function automatic logic [35:0] store_format(input logic [2:0] func3, input logic [1:0] off,
                                               input logic [31:0] rs2);
    logic [31:0] wdata_s;
    logic [3:0]  wstrb_s;
    case (func3)
      3'b000: begin
        wdata_s = {4{rs2[7:0]}};
        wstrb_s = 4'b0001 << off;
      end
      3'b001: begin
        wdata_s = {2{rs2[15:0]}};
        wstrb_s = 4'b0011 << {off[1], 1'b0};
      end
      default: begin
        wdata_s = rs2;
        wstrb_s = 4'b1111;
      end
    endcase
    return {wdata_s, wstrb_s};
  endfunction

  state_t      state_r, state_next_s;
  logic        accept_s, resp_take_s;
  logic        ready_pre_s, valid_post_s, mem_req_valid_s;
  logic        wsel_r, wena_r, csr_wena_r, req_wen_r;
  logic [4:0]  waddr_r;
  logic [2:0]  func3_r;
  logic [3:0]  req_wstrb_r;
  logic [31:0] alu_result_r, csr_waddr_r, csr_wdata_r, mem_result_r;
  logic [31:0] req_addr_r, req_wdata_r;

  // Next-state and handshake decode; reset masks every handshake output.
  always_comb begin
    state_next_s    = state_r;
    ready_pre_s     = 1'b0;
    valid_post_s    = 1'b0;
    mem_req_valid_s = 1'b0;
    accept_s        = 1'b0;
    resp_take_s     = 1'b0;
    if (reset) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          ready_pre_s = 1'b1;
          if (bus.valid_pre_i) begin
            accept_s = 1'b1;
            if (bus.mem_ren_i || bus.mem_wen_i) state_next_s = REQ;
            else                                state_next_s = OUT;
          end else begin
            state_next_s = IDLE;
          end
        end
        REQ: begin
          mem_req_valid_s = 1'b1;
          if (bus.mem_req_ready_i) state_next_s = RESP;
          else                     state_next_s = REQ;
        end
        RESP: begin
          if (bus.mem_resp_valid_i) begin
            resp_take_s  = 1'b1;
            state_next_s = OUT;
          end else begin
            state_next_s = RESP;
          end
        end
        OUT: begin
          valid_post_s = 1'b1;
          if (bus.ready_post_i) state_next_s = IDLE;
          else                  state_next_s = OUT;
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Instruction latch on accept; load result captured on the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      wsel_r       <= 1'b0;
      wena_r       <= 1'b0;
      waddr_r      <= 5'd0;
      alu_result_r <= 32'h0;
      csr_wena_r   <= 1'b0;
      csr_waddr_r  <= 32'h0;
      csr_wdata_r  <= 32'h0;
      func3_r      <= 3'd0;
      mem_result_r <= 32'h0;
      req_wen_r    <= 1'b0;
      req_addr_r   <= 32'h0;
      req_wdata_r  <= 32'h0;
      req_wstrb_r  <= 4'b0000;
    end else if (accept_s) begin
      wsel_r       <= bus.wsel_i;
      wena_r       <= bus.wena_i;
      waddr_r      <= bus.waddr_i;
      alu_result_r <= bus.alu_result_i;
      csr_wena_r   <= bus.csr_wena_i;
      csr_waddr_r  <= bus.csr_waddr_i;
      csr_wdata_r  <= bus.csr_wdata_i;
      func3_r      <= bus.func3_i;
      mem_result_r <= 32'h0;
      req_wen_r    <= bus.mem_wen_i;
      req_addr_r   <= {bus.alu_result_i[31:2], 2'b00};
      if (bus.mem_wen_i) begin
        {req_wdata_r, req_wstrb_r} <= store_format(bus.func3_i, bus.alu_result_i[1:0],
                                                   bus.rs2_data_i);
      end else begin
        req_wdata_r <= 32'h0;
        req_wstrb_r <= 4'b0000;
      end
    end else if (resp_take_s) begin
      mem_result_r <= req_wen_r ? 32'h0
                                : load_extend(func3_r, alu_result_r[1:0], bus.mem_resp_rdata_i);
    end
  end

  assign bus.ready_pre_o     = ready_pre_s;
  assign bus.valid_post_o    = valid_post_s;
  assign bus.mem_req_valid_o = mem_req_valid_s;
  assign bus.mem_req_wen_o   = req_wen_r;
  assign bus.mem_req_addr_o  = req_addr_r;
  assign bus.mem_req_wdata_o = req_wdata_r;
  assign bus.mem_req_wstrb_o = req_wstrb_r;
  assign bus.wsel_o          = wsel_r;
  assign bus.wena_o          = wena_r;
  assign bus.waddr_o         = waddr_r;
  assign bus.alu_result_o    = alu_result_r;
  assign bus.mem_result_o    = mem_result_r;
  assign bus.csr_wena_o      = csr_wena_r;
  assign bus.csr_waddr_o     = csr_waddr_r;
  assign bus.csr_wdata_o     = csr_wdata_r;
endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: a driver, a memory responder
// and an output monitor, checked against a byte-addressed reference memory.
module tb_mem_access;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   n_issued = 0, n_out = 0, n_aborted = 0;

  mem_access_if bus ();
  mem_access dut (.clock(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic ren, wen; logic [2:0] f3; logic [31:0] rs2, alu;
    logic wsel, wena; logic [4:0] waddr; logic csr_wena; logic [31:0] csr_waddr, csr_wdata;
  } instr_t;
  typedef struct {
    logic wsel, wena; logic [4:0] waddr; logic [31:0] alu, memr;
    logic csr_wena; logic [31:0] csr_waddr, csr_wdata; int acc_cyc, lat, hold;
  } exp_out_t;
  typedef struct {
    logic wen; logic [31:0] addr, wdata; logic [3:0] wstrb; int stall, rdelay;
  } exp_req_t;

  exp_out_t    out_q[$];
  exp_req_t    req_q[$];
  logic [7:0]  mbytes[256];   // reference memory, byte addressed by addr[7:0]
  logic [31:0] resp_mem[64];  // responder memory, word addressed by addr[7:2]
  int          rphase = 0;
  bit          mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    resp_mem[idx] = w;
    for (int k = 0; k < 4; k++) mbytes[idx*4 + k] = 8'(w >> (8*k));
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
    logic [31:0] v;
    int b;
    case (f3)
      3'd0, 3'd4: begin
        v = 32'(mbytes[a]);
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        b = int'(a) & 254;
        v = 32'(mbytes[b]) + 32'd256 * 32'(mbytes[b+1]);
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: begin
        b = int'(a) & 252;
        v = 32'd0;
        for (int k = 3; k >= 0; k--) v = v * 32'd256 + 32'(mbytes[b+k]);
      end
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] rs2,
                             output logic [31:0] wdata, output logic [3:0] wstrb);
    int n, base;
    case (f3)
      3'd0: begin n = 1; base = int'(a);       wdata = (rs2 & 32'h0000_00FF) * 32'h0101_0101; end
      3'd1: begin n = 2; base = int'(a) & 254; wdata = (rs2 & 32'h0000_FFFF) * 32'h0001_0001; end
      default: begin n = 4; base = int'(a) & 252; wdata = rs2; end
    endcase
    wstrb = 4'(((1 << n) - 1) << (base % 4));
    for (int k = 0; k < n; k++) mbytes[base + k] = 8'(rs2 >> (8*k));
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    int kind;
    kind        = $urandom_range(0, 3);
    t.ren       = (kind == 1 || kind == 3);
    t.wen       = (kind == 2 || kind == 3);
    t.f3        = t.wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
    t.rs2       = $urandom;
    t.alu       = $urandom;
    t.wsel      = 1'($urandom);
    t.wena      = 1'($urandom);
    t.waddr     = 5'($urandom);
    t.csr_wena  = 1'($urandom);
    t.csr_waddr = $urandom;
    t.csr_wdata = $urandom;
    return t;
  endfunction

  // Drive one instruction until accepted; expectations are pushed at the accept.
  task automatic issue(input instr_t t, input int stall, input int rdelay, input int hold);
    exp_out_t eo;
    exp_req_t er;
    bit       acc;
    acc = 1'b0;
    @(posedge clk); #1;
    bus.mem_ren_i = t.ren;        bus.mem_wen_i = t.wen;       bus.func3_i = t.f3;
    bus.rs2_data_i = t.rs2;       bus.alu_result_i = t.alu;    bus.wsel_i = t.wsel;
    bus.wena_i = t.wena;          bus.waddr_i = t.waddr;       bus.csr_wena_i = t.csr_wena;
    bus.csr_waddr_i = t.csr_waddr; bus.csr_wdata_i = t.csr_wdata;
    bus.valid_pre_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.ready_pre_o === 1'b1) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      fail_now("accept_timeout");
    end else begin
      eo.wsel = t.wsel; eo.wena = t.wena; eo.waddr = t.waddr; eo.alu = t.alu;
      eo.csr_wena = t.csr_wena; eo.csr_waddr = t.csr_waddr; eo.csr_wdata = t.csr_wdata;
      eo.memr = 32'h0; eo.acc_cyc = cyc; eo.hold = hold; eo.lat = 1;
      if (t.ren || t.wen) begin
        er.wen = t.wen; er.addr = t.alu & 32'hFFFF_FFFC; er.stall = stall; er.rdelay = rdelay;
        er.wdata = 32'h0; er.wstrb = 4'b0000;
        if (t.wen) model_store(t.f3, t.alu[7:0], t.rs2, er.wdata, er.wstrb);
        else       eo.memr = model_load(t.f3, t.alu[7:0]);
        eo.lat = 3 + stall + rdelay;
        req_q.push_back(er);
      end
      out_q.push_back(eo);
      n_issued++;
      @(posedge clk); #1;
    end
    bus.valid_pre_i = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_q.size() == 0 && req_q.size() == 0 && rphase == 0 && !mon_busy) begin
        done = 1'b1; break;
      end
    end
    if (!done) fail_now("drain_timeout");
  endtask

  // Memory responder: checks each request, stalls, then answers after a delay.
  initial begin : responder
    exp_req_t    cur;
    int          stall_left, rd_left;
    logic        c_wen;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    bus.mem_req_ready_i = 1'b0; bus.mem_resp_valid_i = 1'b0; bus.mem_resp_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_req_ready_i  = 1'b0;
      case (rphase)
        0: if (bus.mem_req_valid_o === 1'b1) begin
          c_wen = bus.mem_req_wen_o; c_addr = bus.mem_req_addr_o;
          c_wdata = bus.mem_req_wdata_o; c_wstrb = bus.mem_req_wstrb_o;
          if (req_q.size() == 0) begin
            fail_now("unexpected_mem_request");
            cur.stall = 0; cur.rdelay = 0;
          end else begin
            cur = req_q.pop_front();
            chk("req_wen", c_wen, cur.wen);
            chk("req_addr", c_addr, cur.addr);
            chk("req_wstrb", c_wstrb, cur.wstrb);
            if (cur.wen) chk("req_wdata", c_wdata, cur.wdata);
          end
          stall_left = cur.stall;
          rphase = 1;
        end
        default: ;
      endcase
      if (rphase == 1) begin
        if (stall_left != cur.stall) begin
          chk("req_valid_held", bus.mem_req_valid_o, 1'b1);
          chk("req_addr_held", bus.mem_req_addr_o, c_addr);
          chk("req_wen_held", bus.mem_req_wen_o, c_wen);
          chk("req_wdata_held", bus.mem_req_wdata_o, c_wdata);
          chk("req_wstrb_held", bus.mem_req_wstrb_o, c_wstrb);
        end
        if (stall_left == 0) begin
          bus.mem_req_ready_i  = 1'b1;
          // A response in the handshake cycle must be ignored by the stage.
          bus.mem_resp_valid_i = 1'($urandom);
          bus.mem_resp_rdata_i = $urandom;
          rd_left = cur.rdelay;
          rphase  = 2;
        end else begin
          stall_left--;
        end
      end else if (rphase == 2 && bus.mem_req_ready_i === 1'b0) begin
        chk("req_valid_dropped", bus.mem_req_valid_o, 1'b0);
        if (rd_left == 0) begin
          if (c_wen) begin
            for (int k = 0; k < 4; k++)
              if (c_wstrb[k]) resp_mem[c_addr[7:2]][8*k +: 8] = c_wdata[8*k +: 8];
            bus.mem_resp_rdata_i = $urandom;
          end else begin
            bus.mem_resp_rdata_i = resp_mem[c_addr[7:2]];
          end
          bus.mem_resp_valid_i = 1'b1;
          rphase = 0;
        end else begin
          rd_left--;
        end
      end
    end
  end

  // Output monitor: pops an expectation on the first valid cycle, then checks hold.
  initial begin : monitor
    exp_out_t cur;
    int       hold_left, hs_cyc;
    bit       hs_pend;
    hs_pend = 1'b0; hs_cyc = 0; hold_left = 0;
    bus.ready_post_i = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_pend && cyc == hs_cyc + 1) begin
        hs_pend = 1'b0;
        if (!reset) chk("ready_pre_after_out", bus.ready_pre_o, 1'b1);
      end
      if (bus.valid_post_o === 1'b1) begin
        if (!mon_busy) begin
          if (out_q.size() == 0) begin
            fail_now("unexpected_valid_post");
            hold_left = 0;
          end else begin
            cur = out_q.pop_front();
            n_out++;
            mon_busy = 1'b1;
            hold_left = cur.hold;
            chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
            chk("mem_result", bus.mem_result_o, cur.memr);
          end
        end else begin
          chk("mem_result_held", bus.mem_result_o, cur.memr);
        end
        if (mon_busy) begin
          chk("alu_result", bus.alu_result_o, cur.alu);
          chk("wsel", bus.wsel_o, cur.wsel);
          chk("wena", bus.wena_o, cur.wena);
          chk("waddr", bus.waddr_o, cur.waddr);
          chk("csr_wena", bus.csr_wena_o, cur.csr_wena);
          chk("csr_waddr", bus.csr_waddr_o, cur.csr_waddr);
          chk("csr_wdata", bus.csr_wdata_o, cur.csr_wdata);
        end
        chk("ready_pre_in_out", bus.ready_pre_o, 1'b0);
        if (hold_left == 0) begin
          bus.ready_post_i = 1'b1;
          mon_busy = 1'b0;
          hs_pend = 1'b1;
          hs_cyc = cyc;
        end else begin
          bus.ready_post_i = 1'b0;
          hold_left--;
        end
      end else begin
        bus.ready_post_i = 1'b0;
        if (mon_busy) begin
          fail_now("valid_post_dropped_early");
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    instr_t t;
    bit     seen;
    bus.valid_pre_i = 1'b0; bus.mem_ren_i = 1'b0; bus.mem_wen_i = 1'b0; bus.func3_i = 3'd0;
    bus.rs2_data_i = 32'h0; bus.alu_result_i = 32'h0; bus.wsel_i = 1'b0; bus.wena_i = 1'b0;
    bus.waddr_i = 5'd0; bus.csr_wena_i = 1'b0; bus.csr_waddr_i = 32'h0; bus.csr_wdata_i = 32'h0;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_pre", bus.ready_pre_o, 1'b0);
    chk("rst_valid_post", bus.valid_post_o, 1'b0);
    chk("rst_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst_alu_result", bus.alu_result_o, 32'h0);
    chk("rst_mem_result", bus.mem_result_o, 32'h0);
    chk("rst_csr_wdata", bus.csr_wdata_o, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_ready_pre", bus.ready_pre_o, 1'b1);

    // Non-memory pass-through
    t = rand_instr(); t.ren = 1'b0; t.wen = 1'b0; t.alu = 32'h0000_1234; t.wena = 1'b1; t.waddr = 5'd5;
    issue(t, 0, 0, 0); wait_done();

    // LB / LBU at 0x103 against word 0x80FF_0000
    set_word(0, 32'h80FF_0000);
    t = rand_instr(); t.ren = 1'b1; t.wen = 1'b0; t.f3 = 3'd0; t.alu = 32'h0000_0103;
    issue(t, 0, 0, 0); wait_done();
    t.f3 = 3'd4;
    issue(t, 0, 0, 0); wait_done();

    // SH at 0x202
    t = rand_instr(); t.ren = 1'b0; t.wen = 1'b1; t.f3 = 3'd1; t.alu = 32'h0000_0202; t.rs2 = 32'hAAAA_BEEF;
    issue(t, 0, 0, 0); wait_done();

    // Request stalled 3 cycles, response 2 cycles later
    t = rand_instr(); t.ren = 1'b1; t.wen = 1'b0;
    issue(t, 3, 2, 0); wait_done();

    // wback stalls 4 cycles; the next instruction is offered meanwhile
    t = rand_instr(); t.ren = 1'b0; t.wen = 1'b0;
    issue(t, 0, 0, 4);
    t = rand_instr(); t.ren = 1'b0; t.wen = 1'b0;
    issue(t, 0, 0, 0); wait_done();

    // Reset while waiting for the response; the late response must be ignored
    t = rand_instr(); t.ren = 1'b1; t.wen = 1'b0;
    issue(t, 0, 6, 0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rphase == 2) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("resp_phase_timeout");
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_pre", bus.ready_pre_o, 1'b0);
    chk("rst_mid_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst_mid_valid_post", bus.valid_post_o, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    out_q.delete();
    n_aborted++;
    chk("abort_alu_result", bus.alu_result_o, 32'h0);
    chk("abort_waddr", bus.waddr_o, 32'h0);
    chk("abort_wena", bus.wena_o, 1'b0);
    chk("abort_csr_waddr", bus.csr_waddr_o, 32'h0);
    chk("abort_ready_pre", bus.ready_pre_o, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    chk("abort_no_valid_post", bus.valid_post_o, 1'b0);
    chk("abort_idle", bus.ready_pre_o, 1'b1);
    t = rand_instr(); t.ren = 1'b1; t.wen = 1'b0;
    issue(t, 0, 0, 0); wait_done();

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      int z;
      t = rand_instr();
      z = ($urandom_range(0, 3) == 0) ? 1 : 0;
      issue(t, z ? 0 : $urandom_range(0, 3), z ? 0 : $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();
    chk("output_count", 32'(n_out), 32'(n_issued - n_aborted));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
